// File: rtl/pulse_train_gen_if.sv
// Control/status bundle for pulse_train_gen: train request and length controls in,
// serial pulse output and progress status out.
interface pulse_train_gen_if #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned NUM_W = 8
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] high_len;
    logic [LEN_W-1:0] low_len;
    logic [NUM_W-1:0] num_pulses;
    logic             z;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulses_sent;

    modport master (
        output start, abort, high_len, low_len, num_pulses,
        input  z, busy, done, pulses_sent
    );

    modport slave (
        input  start, abort, high_len, low_len, num_pulses,
        output z, busy, done, pulses_sent
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: num_pulses periods of high_len cycles high then
// low_len cycles low on z, followed by a one-cycle done strobe. All outputs are flops.
module pulse_train_gen #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned NUM_W = 8
) (
    input logic              clk,
    input logic              reset,
    pulse_train_gen_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] hl_q, hl_d;
    logic [LEN_W-1:0] ll_q, ll_d;
    logic [NUM_W-1:0] n_q, n_d;
    logic [NUM_W-1:0] sent_q, sent_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Zero-length phases are stretched to one cycle so every period has an edge.
    logic [LEN_W-1:0] hl_eff, ll_eff;
    logic [NUM_W-1:0] sent_inc;

    assign hl_eff   = (bus.high_len == '0) ? LEN_W'(1) : bus.high_len;
    assign ll_eff   = (bus.low_len == '0) ? LEN_W'(1) : bus.low_len;
    assign sent_inc = sent_q + NUM_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hl_q    <= '0;
            ll_q    <= '0;
            n_q     <= '0;
            sent_q  <= '0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hl_q    <= hl_d;
            ll_q    <= ll_d;
            n_q     <= n_d;
            sent_q  <= sent_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hl_d    = hl_q;
        ll_d    = ll_q;
        n_d     = n_q;
        sent_d  = sent_q;
        z_d     = z_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort has priority over a simultaneous start
                if (bus.start && !bus.abort) begin
                    sent_d = '0;
                    if (bus.num_pulses == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        hl_d    = hl_eff;
                        ll_d    = ll_eff;
                        n_d     = bus.num_pulses;
                        cnt_d   = hl_eff - LEN_W'(1);
                        state_d = StHigh;
                        z_d     = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            StHigh: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    z_d     = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else begin
                    state_d = StLow;
                    z_d     = 1'b0;
                    cnt_d   = ll_q - LEN_W'(1);
                end
            end
            StLow: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    z_d     = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else begin
                    sent_d = sent_inc;
                    if (sent_inc == n_q) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StHigh;
                        z_d     = 1'b1;
                        cnt_d   = hl_q - LEN_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                z_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.z           = z_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: per-cycle comparison against a period-based
// arithmetic model of the expected waveform, plus rising-edge counting on z.
module tb_pulse_train_gen;

    logic clk;
    logic reset;
    int   chk_cnt;
    int   pass_cnt;

    pulse_train_gen_if #(.LEN_W(8), .NUM_W(8)) bus ();

    pulse_train_gen #(.LEN_W(8), .NUM_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one train: start asserted one cycle (or held), optional abort after
    // sampling cycle a. Cycle i is sampled 1ns after edge k+i, k being the start edge.
    task automatic run_train(input int hl, input int ll, input int n, input int a,
                             input bit hold_start, input string tag);
        int         hle, lle, p, total, last, edges;
        logic       ez, eb, ed, zprev;
        logic [7:0] es;
        hle   = (hl == 0) ? 1 : hl;
        lle   = (ll == 0) ? 1 : ll;
        p     = hle + lle;
        total = n * p;
        if (a >= 0) last = a + 2;
        else if (hold_start) last = total + 2;
        else last = total + 1;
        bus.high_len   = 8'(hl);
        bus.low_len    = 8'(ll);
        bus.num_pulses = 8'(n);
        bus.start      = 1'b1;
        bus.abort      = 1'b0;
        zprev = 1'b0;
        edges = 0;
        for (int i = 0; i <= last; i++) begin
            @(posedge clk);
            #1;
            if (a >= 0 && i > a) begin
                ez = 0; eb = 0; ed = 0; es = 8'(a / p);
            end else if (i < total) begin
                ez = ((i % p) < hle); eb = 1; ed = 0; es = 8'(i / p);
            end else if (i == total) begin
                ez = 0; eb = 0; ed = 1; es = 8'(n);
            end else if (i == total + 1) begin
                ez = 0; eb = 0; ed = 0; es = 8'(n);
            end else begin
                ez = 1; eb = 1; ed = 0; es = 8'(0);
            end
            chk_cnt++;
            if (bus.z !== ez)
                $display("FAIL %s z cycle %0d: got %b want %b", tag, i, bus.z, ez);
            else pass_cnt++;
            chk_cnt++;
            if (bus.busy !== eb)
                $display("FAIL %s busy cycle %0d: got %b want %b", tag, i, bus.busy, eb);
            else pass_cnt++;
            chk_cnt++;
            if (bus.done !== ed)
                $display("FAIL %s done cycle %0d: got %b want %b", tag, i, bus.done, ed);
            else pass_cnt++;
            chk_cnt++;
            if (bus.pulses_sent !== es)
                $display("FAIL %s pulses_sent cycle %0d: got %0d want %0d", tag, i,
                         bus.pulses_sent, es);
            else pass_cnt++;
            if (bus.z === 1'b1 && zprev === 1'b0) edges++;
            zprev = bus.z;
            // Scramble the live inputs: only the latched copies may matter.
            if (!hold_start) bus.start = 1'b0;
            bus.high_len   = 8'($urandom);
            bus.low_len    = 8'($urandom);
            bus.num_pulses = 8'($urandom_range(1, 255));
            bus.abort      = (i == a);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (a < 0 && !hold_start) begin
            chk_cnt++;
            if (edges !== n)
                $display("FAIL %s rising_edges: got %0d want %0d", tag, edges, n);
            else pass_cnt++;
        end
        if (hold_start) begin
            // Stop the restarted train so the next scenario begins from idle.
            bus.abort = 1'b1;
            @(posedge clk);
            #1;
            bus.abort = 1'b0;
            chk_cnt++;
            if (bus.busy !== 1'b0 || bus.z !== 1'b0)
                $display("FAIL %s cleanup: got busy=%b z=%b want 0 0", tag, bus.busy, bus.z);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.high_len   = '0;
        bus.low_len    = '0;
        bus.num_pulses = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if ({bus.z, bus.busy, bus.done, bus.pulses_sent} !== 11'd0)
            $display("FAIL reset_state: got z=%b busy=%b done=%b sent=%0d want all 0",
                     bus.z, bus.busy, bus.done, bus.pulses_sent);
        else pass_cnt++;
        #3 reset = 1'b1;
    endtask

    task automatic test_async_reset_mid_train();
        @(posedge clk);
        #1;
        bus.high_len   = 8'd4;
        bus.low_len    = 8'd2;
        bus.num_pulses = 8'd3;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (bus.z !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL mid_train_pre: got z=%b busy=%b want 1 1", bus.z, bus.busy);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.z, bus.busy, bus.done, bus.pulses_sent} !== 11'd0)
            $display("FAIL async_reset: got z=%b busy=%b done=%b sent=%0d want all 0",
                     bus.z, bus.busy, bus.done, bus.pulses_sent);
        else pass_cnt++;
        @(posedge clk);
        #4 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (bus.z !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL post_reset_idle cycle %0d: got z=%b busy=%b want 0 0",
                         i, bus.z, bus.busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_directed();
        run_train(2, 3, 3, -1, 1'b0, "basic_2_3_3");
        run_train(0, 0, 4, -1, 1'b0, "zero_len");
        run_train(1, 1, 0, -1, 1'b0, "zero_pulses");
    endtask

    task automatic test_abort();
        run_train(3, 2, 5, 6, 1'b0, "abort_2nd_high");
    endtask

    task automatic test_start_ignored();
        run_train(1, 2, 2, -1, 1'b1, "start_held");
    endtask

    task automatic test_loopback();
        run_train(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1, -1, 1'b0,
                  "loop_1");
        run_train(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2, -1, 1'b0,
                  "loop_2");
        run_train(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 255, -1, 1'b0,
                  "loop_255");
    endtask

    task automatic test_back_to_back();
        int hl, ll, n, a;
        for (int t = 0; t < 10; t++) begin
            hl = int'($urandom_range(0, 4));
            ll = int'($urandom_range(0, 4));
            n  = int'($urandom_range(0, 6));
            a  = -1;
            if (n > 0 && $urandom_range(0, 2) == 0) begin
                a = int'($urandom_range(0, n * (((hl == 0) ? 1 : hl) +
                                                ((ll == 0) ? 1 : ll)) - 1));
            end
            run_train(hl, ll, n, a, 1'b0, "random");
        end
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_async_reset_mid_train();
        test_directed();
        test_abort();
        test_start_ignored();
        test_loopback();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
